// File: rtl/pcw_dn_pkg.sv
// Shared types for the boot-image download writer.
//   dn_state_t : controller states (IDLE, LOAD, DRAIN, START)
//   dn_entry_t : one buffered download byte with its image address
//   DN_CHK_W   : width of the running image checksum
package pcw_dn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    START = 2'd3
  } dn_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } dn_entry_t;

  localparam int DN_CHK_W = 16;

endpackage

// File: rtl/pcw_dn_ram_writer_fifo.sv
// pcw_dn_fifo: small synchronous FIFO of dn_entry_t.
// Ports:
//   clk_sys, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din        : write an entry (caller only pushes when not full or
//                      when popping in the same cycle)
//   pop, dout        : remove the head; dout always shows the head
//   full, empty      : occupancy flags
//   count            : current number of entries (0..DEPTH)
// DEPTH must be a power of two, minimum 2, so the pointers wrap naturally.
module pcw_dn_fifo
  import pcw_dn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  dn_entry_t              din,
  input  logic                   pop,
  output dn_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  dn_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // push and pop together (even when full) leave the count unchanged
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/pcw_dn_ram_writer.sv
// pcw_dn_ram_writer: buffers the boot-loader byte stream, commits it to
// system RAM through the arbiter, holds the Z80 until the image is written,
// then issues a one-cycle CPU start carrying the latched execute address.
// Ports:
//   clk_sys, reset_n           : clock, synchronous active-low reset
//   dn_go/dn_wr/dn_addr/dn_data: download window and byte strobe
//   dn_wait                    : backpressure, FIFO count >= FIFO_DEPTH-1
//   execute_enable/execute_addr: start PC capture
//   ram_req/ram_addr/ram_din   : write request from the FIFO head
//   ram_gnt                    : one-cycle accept, pops the head
//   cpu_hold/cpu_start/cpu_start_pc : CPU control
//   busy, overflow, byte_count, checksum : status
// Build option: PCW_DN_CHECKSUM_EN enables the 16-bit sum of written bytes;
// without it the checksum port is tied to zero.
//
// state | meaning
// IDLE  | no download; CPU free
// LOAD  | download window open, bytes buffered and written
// DRAIN | window closed, flushing remaining FIFO entries
// START | single cycle: cpu_start pulse, cpu_hold released
module pcw_dn_ram_writer
  import pcw_dn_pkg::*;
#(
  parameter int                RAM_AW     = 21,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [RAM_AW-1:0] BOOT_BASE  = '0
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                dn_go,
  input  logic                dn_wr,
  input  logic [15:0]         dn_addr,
  input  logic [7:0]          dn_data,
  output logic                dn_wait,
  input  logic                execute_enable,
  input  logic [15:0]         execute_addr,
  output logic                ram_req,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [7:0]          ram_din,
  input  logic                ram_gnt,
  output logic                cpu_hold,
  output logic                cpu_start,
  output logic [15:0]         cpu_start_pc,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         byte_count,
  output logic [DN_CHK_W-1:0] checksum
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dn_state_t   state_q, state_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        cpu_start_q, cpu_start_d;
  logic [15:0] cpu_start_pc_q, cpu_start_pc_d;
  logic        exec_seen_q, exec_seen_d;
  logic        overflow_q, overflow_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic        dn_wait_q, dn_wait_d;

  logic          push_req, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_nxt;
  dn_entry_t     head, entry_in;

  assign entry_in = '{addr: dn_addr, data: dn_data};

  pcw_dn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .din     (entry_in),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    push_req  = (state_q == LOAD) & dn_go & dn_wr;
    pop       = ram_gnt & ~fifo_empty;
    // a full FIFO still accepts a byte when the head leaves in the same cycle
    push      = push_req & (~fifo_full | pop);
    count_nxt = fifo_count + CW'(push) - CW'(pop);
  end

`ifdef PCW_DN_CHECKSUM_EN
  logic [DN_CHK_W-1:0] checksum_q, checksum_d;
`endif

  always_comb begin
    state_d        = state_q;
    cpu_hold_d     = cpu_hold_q;
    cpu_start_pc_d = cpu_start_pc_q;
    exec_seen_d    = exec_seen_q;
    overflow_d     = overflow_q;
    byte_count_d   = byte_count_q;
`ifdef PCW_DN_CHECKSUM_EN
    checksum_d     = checksum_q;
`endif

    if (push_req & ~push) overflow_d = 1'b1;
    if (pop) begin
      byte_count_d = byte_count_q + 16'd1;
`ifdef PCW_DN_CHECKSUM_EN
      checksum_d   = checksum_q + DN_CHK_W'(head.data);
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (dn_go) begin
          state_d      = LOAD;
          cpu_hold_d   = 1'b1;
          byte_count_d = '0;
          overflow_d   = 1'b0;
          exec_seen_d  = 1'b0;
`ifdef PCW_DN_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      LOAD:  if (!dn_go) state_d = DRAIN;
      DRAIN: begin
        if (dn_go)                state_d = LOAD;
        else if (count_nxt == '0) state_d = START;
      end
      START: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (execute_enable && state_q != IDLE) begin
      cpu_start_pc_d = execute_addr;
      exec_seen_d    = 1'b1;
    end

    // entering START: release the CPU; no execute seen means PC 0
    if (state_d == START) begin
      cpu_hold_d = 1'b0;
      if (!exec_seen_d) cpu_start_pc_d = '0;
    end

    cpu_start_d = (state_d == START);
    // computed from the post-edge count so a one-cycle-late upstream fits
    dn_wait_d   = (count_nxt >= CW'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cpu_hold_q     <= 1'b0;
      cpu_start_q    <= 1'b0;
      cpu_start_pc_q <= '0;
      exec_seen_q    <= 1'b0;
      overflow_q     <= 1'b0;
      byte_count_q   <= '0;
      dn_wait_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cpu_hold_q     <= cpu_hold_d;
      cpu_start_q    <= cpu_start_d;
      cpu_start_pc_q <= cpu_start_pc_d;
      exec_seen_q    <= exec_seen_d;
      overflow_q     <= overflow_d;
      byte_count_q   <= byte_count_d;
      dn_wait_q      <= dn_wait_d;
    end
  end

`ifdef PCW_DN_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign ram_req      = ~fifo_empty;
  assign ram_addr     = BOOT_BASE + RAM_AW'(head.addr);
  assign ram_din      = head.data;
  assign dn_wait      = dn_wait_q;
  assign cpu_hold     = cpu_hold_q;
  assign cpu_start    = cpu_start_q;
  assign cpu_start_pc = cpu_start_pc_q;
  assign busy         = (state_q != IDLE);
  assign overflow     = overflow_q;
  assign byte_count   = byte_count_q;

endmodule

// File: doc/pcw_dn_ram_writer.md
Name: pcw_dn_ram_writer

Overview:
- Sits inside pcw_core, directly downstream of the top-level boot-loader sequencer.
- Consumes the dn_go/dn_wr/dn_addr/dn_data byte stream and buffers it in a small FIFO.
- Writes the bytes into system RAM through the RAM arbiter and holds the Z80 until the image is fully committed.
- Then issues a one-cycle CPU start with the latched execute address.

Parameters:
- RAM_AW, 21, RAM byte-address width (2 MB).
- FIFO_DEPTH, 4, entries of {addr, data}; power of two, minimum 2.
- BOOT_BASE, 0, RAM_AW-bit base added to dn_addr (zero-extended) to form ram_addr.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dn_go  in  1  download window active (level).
- dn_wr  in  1  byte strobe, valid only while dn_go=1.
- dn_addr  in  16  byte address within the image.
- dn_data  in  8  byte value.
- dn_wait  out  1  backpressure to the upstream sequencer.
- execute_enable  in  1  one-cycle pulse: the image is runnable.
- execute_addr  in  16  CPU start PC, sampled on execute_enable.
- ram_req  out  1  write request to the RAM arbiter.
- ram_addr  out  RAM_AW  write address.
- ram_din  out  8  write data.
- ram_gnt  in  1  one-cycle accept of the current request.
- cpu_hold  out  1  keep the Z80 in reset/wait.
- cpu_start  out  1  one-cycle release pulse.
- cpu_start_pc  out  16  PC for the CPU; valid when cpu_start=1.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky: a byte was dropped.
- byte_count  out  16  bytes committed to RAM in this session.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset (reset_n=0 on a clock edge):
  - State goes to IDLE and the FIFO is emptied.
  - All outputs go to 0; cpu_start_pc=0 and exec_seen=0.
  - Reset mid-download abandons the remaining FIFO contents. No partial pulse is emitted.
- IDLE:
  - On dn_go=1: go to LOAD, set cpu_hold=1, clear byte_count, checksum, overflow and exec_seen.
- LOAD:
  - A push occurs on dn_wr & dn_go.
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and overflow is set.
  - A push and a pop in the same cycle are allowed, including when the FIFO is full; the count is unchanged.
  - dn_wr while dn_go=0 is ignored in every state.
- Write side (LOAD and DRAIN):
  - ram_req = FIFO not empty, with ram_addr = BOOT_BASE + head.addr and ram_din = head.data, driven combinationally from the head.
  - ram_gnt pops the head and increments byte_count; byte_count wraps at 16 bits.
  - ram_gnt is ignored when ram_req=0.
  - Latency from push to the earliest ram_req is one cycle.
- dn_wait = FIFO count >= FIFO_DEPTH-1 (registered). A one-cycle-late honouring upstream therefore never overflows.
- execute_enable in any non-IDLE state: latch execute_addr into cpu_start_pc and set exec_seen=1. A later pulse overwrites the PC.
- dn_go falling in LOAD: go to DRAIN.
- dn_go rising again in DRAIN: return to LOAD, keeping FIFO contents and counts.
- DRAIN:
  - Wait for the FIFO to empty. The next cycle may be the same one as the last ram_gnt pop.
  - Then go to START.
  - execute_enable arriving in the same cycle as the dn_go fall is captured.
- START (single cycle):
  - cpu_start=1 and cpu_hold=0 (registered).
  - If exec_seen=0, cpu_start_pc=0.
  - Next state IDLE.
- busy=1 in LOAD, DRAIN and START.

Optional Feature:
- Macro: PCW_DN_CHECKSUM_EN.
- Defined: checksum is a 16-bit wrapping sum of ram_din over every granted write, cleared on entry to LOAD and held after START.
- Undefined: the port remains and is tied to 0; no adder is synthesised.

Decomposition:
- Package pcw_dn_pkg holds:
  - dn_state_t enum {IDLE, LOAD, DRAIN, START};
  - dn_entry_t struct {logic [15:0] addr; logic [7:0] data};
  - localparam DN_CHK_W = 16.
- Sub-module pcw_dn_fifo:
  - synchronous FIFO of dn_entry_t, depth FIFO_DEPTH;
  - push/pop/full/empty/count;
  - synchronous active-low reset;
  - simultaneous push+pop when full is legal.

Test Plan:
- Basic load:
  - Stimulus: dn_go, then 4 bytes at 0x0000..0x0003 = AA,55,01,FF; ram_gnt always 1; then execute_enable with addr 0x0000; dn_go falls.
  - Response: 4 RAM writes in order; byte_count=4; checksum=0x01FF with macro; one cpu_start with pc=0x0000; cpu_hold low after START.
- Backpressure:
  - Stimulus: ram_gnt held 0, upstream pushes one byte per cycle while honouring dn_wait.
  - Response: dn_wait rises at count 3; overflow=0; after the grants resume, all bytes are written in order.
- Overflow:
  - Stimulus: ram_gnt held 0 and 6 pushes ignoring dn_wait.
  - Response: 4 bytes retained; overflow=1 sticky until the next dn_go rise.
- No execute:
  - Stimulus: dn_go falls with no execute_enable.
  - Response: cpu_start pulses with cpu_start_pc=0x0000.
- Reset mid-DRAIN:
  - Stimulus: reset_n=0 for one cycle with 3 entries queued.
  - Response: ram_req=0, cpu_hold=0 and busy=0 next cycle; no cpu_start.
- BOOT_BASE:
  - Stimulus: BOOT_BASE=0x10000, byte at dn_addr 0x0113.
  - Response: ram_addr=0x10113.
